// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//
// Round-robin arbiter for the common data bus. Each functional unit owns a
// one-entry holding slot; at most one full slot is broadcast per cycle on a
// registered CDB. The search starts at rr_ptr and wraps modulo NREQ, and the
// pointer moves to the unit after the winner, so no unit can starve.
//
// Ports:
//   clk_in     clock, all state changes on the rising edge
//   rst_in     asynchronous active-low reset
//   rdy_in     global ready; low freezes every register
//   flush_in   synchronous misprediction flush (drops every held result)
//   req_valid  unit i presents a result
//   req_tag    ROB tag of unit i at [i*TAG_W +: TAG_W]
//   req_value  result of unit i at [i*32 +: 32]
//   req_ready  slot i accepts this cycle
//   cdb_valid  registered broadcast valid
//   cdb_tag    registered broadcast ROB tag
//   cdb_value  registered broadcast value
//   cdb_src    registered index of the winning unit
module cdb_arbiter #(
  parameter int NREQ  = 3,
  parameter int TAG_W = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*TAG_W-1:0] req_tag,
  input  logic [NREQ*32-1:0]    req_value,
  output logic [NREQ-1:0]       req_ready,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [31:0]           cdb_value,
  output logic [1:0]            cdb_src
);

  logic [NREQ-1:0]  full;
  logic [TAG_W-1:0] slot_tag   [NREQ];
  logic [31:0]      slot_value [NREQ];
  logic [1:0]       rr_ptr;

  logic [NREQ-1:0]  grant;
  logic             grant_any;
  logic [1:0]       grant_idx;
  logic [1:0]       next_ptr;
  logic [NREQ-1:0]  accept;

  // Search the full bits starting at rr_ptr and wrapping; the first full
  // slot wins. Incoming requests are never considered, so a result always
  // spends at least one cycle in its slot before it can be broadcast.
  always_comb begin : arbitrate
    int idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && idx < NREQ && full[idx]) begin
        grant[idx] = 1'b1;
        grant_any  = 1'b1;
        grant_idx  = idx[1:0];
      end
    end
    if (int'(grant_idx) == NREQ - 1) next_ptr = '0;
    else                             next_ptr = grant_idx + 2'd1;
  end

  // A slot can take a new result when it is empty or is being drained this
  // cycle, which lets one unit stream a result every cycle. Reset is folded
  // in so no unit sees ready while the arbiter is held in reset.
  always_comb begin
    req_ready = {NREQ{rst_in & rdy_in & ~flush_in}} & (~full | grant);
    accept    = req_valid & req_ready;
  end

  // Slot and CDB state. Flush outranks accept and grant; rdy_in low freezes
  // everything including the broadcast registers, which consumers qualify
  // with rdy_in themselves.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      full      <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_tag[i]   <= '0;
        slot_value[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        full      <= '0;
        rr_ptr    <= '0;
        cdb_valid <= 1'b0;
      end else begin
        for (int i = 0; i < NREQ; i++) begin
          if (accept[i]) begin
            full[i]       <= 1'b1;
            slot_tag[i]   <= req_tag[i*TAG_W +: TAG_W];
            slot_value[i] <= req_value[i*32 +: 32];
          end else if (grant[i]) begin
            full[i] <= 1'b0;
          end
        end
        cdb_valid <= grant_any;
        if (grant_any) begin
          cdb_tag   <= slot_tag[grant_idx];
          cdb_value <= slot_value[grant_idx];
          cdb_src   <= grant_idx;
          rr_ptr    <= next_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter with hand-computed expectations: single
// result, wrap-around, flush, three-way contention, back-to-back streaming
// from one unit, rdy_in stall and asynchronous reset.
module tb_cdb_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        flush_in;
  logic [2:0]  req_valid;
  logic [11:0] req_tag;
  logic [95:0] req_value;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;

  int checks;
  int errors;

  cdb_arbiter #(.NREQ(3), .TAG_W(4)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_value (req_value),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the request bus: valid bits, packed tags and packed values.
  task automatic applyStimulus(input logic [2:0] v, input logic [11:0] t,
                               input logic [95:0] d);
    req_valid = v;
    req_tag   = t;
    req_value = d;
  endtask

  // Advance one rising edge and step just past it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Compare the whole registered CDB in one go.
  task automatic checkCdb(input string tag, input logic v, input logic [3:0] t,
                          input logic [31:0] d, input logic [1:0] s);
    checkOutput({tag, ".valid"}, 32'(cdb_valid), 32'(v));
    checkOutput({tag, ".tag"},   32'(cdb_tag),   32'(t));
    checkOutput({tag, ".value"}, cdb_value,      d);
    checkOutput({tag, ".src"},   32'(cdb_src),   32'(s));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_in   = 1'b0;
    rdy_in   = 1'b1;
    flush_in = 1'b0;
    applyStimulus(3'b000, 12'h000, 96'h0);

    // Reset state
    tick();
    tick();
    checkCdb("reset", 1'b0, 4'd0, 32'h0, 2'd0);
    checkOutput("reset.ready", 32'(req_ready), 32'h0);
    checkOutput("reset.rr_ptr", 32'(dut.rr_ptr), 32'd0);
    rst_in = 1'b1;
    #1;
    checkOutput("post_reset.ready", 32'(req_ready), 32'h7);

    // Single result from unit 1: tag 5, 0xDEADBEEF
    tick();
    applyStimulus(3'b010, {4'd0, 4'd5, 4'd0}, {32'h0, 32'hDEADBEEF, 32'h0});
    #1;
    checkOutput("single.ready1", 32'(req_ready[1]), 32'd1);
    tick();
    applyStimulus(3'b000, 12'h000, 96'h0);
    #1;
    checkOutput("single.pre_cdb", 32'(cdb_valid), 32'd0);
    checkOutput("single.full", 32'(dut.full), 32'b010);
    tick();
    checkCdb("single.cdb", 1'b1, 4'd5, 32'hDEADBEEF, 2'd1);
    checkOutput("single.rr_ptr", 32'(dut.rr_ptr), 32'd2);
    tick();
    checkOutput("single.once", 32'(cdb_valid), 32'd0);

    // Wrap-around: rr_ptr=2, fill slots 0 (tag 6) and 2 (tag 7)
    applyStimulus(3'b101, {4'd7, 4'd0, 4'd6}, {32'h7777, 32'h0, 32'h6666});
    tick();
    applyStimulus(3'b000, 12'h000, 96'h0);
    #1;
    checkOutput("wrap.ready", 32'(req_ready), 32'b110);
    tick();
    checkCdb("wrap.first", 1'b1, 4'd7, 32'h7777, 2'd2);
    tick();
    checkCdb("wrap.second", 1'b1, 4'd6, 32'h6666, 2'd0);
    checkOutput("wrap.rr_ptr", 32'(dut.rr_ptr), 32'd1);
    tick();
    checkOutput("wrap.idle", 32'(cdb_valid), 32'd0);

    // Flush: fill slots 0 and 2, flush on the next cycle
    applyStimulus(3'b101, {4'd14, 4'd0, 4'd13}, {32'hEEEE, 32'h0, 32'hDDDD});
    tick();
    applyStimulus(3'b000, 12'h000, 96'h0);
    flush_in = 1'b1;
    #1;
    checkOutput("flush.ready", 32'(req_ready), 32'h0);
    tick();
    flush_in = 1'b0;
    #1;
    checkOutput("flush.cdb_valid", 32'(cdb_valid), 32'd0);
    checkOutput("flush.full", 32'(dut.full), 32'h0);
    checkOutput("flush.rr_ptr", 32'(dut.rr_ptr), 32'd0);
    tick();
    checkOutput("flush.no_late_bcast", 32'(cdb_valid), 32'd0);

    // Contention: rr_ptr=0, fill all three slots with tags 1, 2, 3
    applyStimulus(3'b111, {4'd3, 4'd2, 4'd1}, {32'h300, 32'h200, 32'h100});
    tick();
    applyStimulus(3'b000, 12'h000, 96'h0);
    #1;
    checkOutput("cont.ready_a", 32'(req_ready), 32'b001);
    tick();
    checkCdb("cont.b0", 1'b1, 4'd1, 32'h100, 2'd0);
    checkOutput("cont.ready_b", 32'(req_ready), 32'b011);
    tick();
    checkCdb("cont.b1", 1'b1, 4'd2, 32'h200, 2'd1);
    checkOutput("cont.ready_c", 32'(req_ready), 32'b111);
    tick();
    checkCdb("cont.b2", 1'b1, 4'd3, 32'h300, 2'd2);
    tick();
    checkOutput("cont.idle", 32'(cdb_valid), 32'd0);

    // Back-to-back: unit 0 streams tags 8..11
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b001, {8'h00, 4'(8 + k)}, {64'h0, 32'(32'hB000 + k)});
      #1;
      checkOutput($sformatf("b2b.ready%0d", k), 32'(req_ready[0]), 32'd1);
      if (k >= 2)
        checkCdb($sformatf("b2b.cdb%0d", k - 2), 1'b1, 4'(8 + k - 2),
                 32'(32'hB000 + k - 2), 2'd0);
      else if (k == 1)
        checkOutput("b2b.latency", 32'(cdb_valid), 32'd0);
      tick();
    end
    applyStimulus(3'b000, 12'h000, 96'h0);
    checkCdb("b2b.cdb2", 1'b1, 4'd10, 32'hB002, 2'd0);
    tick();
    checkCdb("b2b.cdb3", 1'b1, 4'd11, 32'hB003, 2'd0);
    tick();
    checkOutput("b2b.idle", 32'(cdb_valid), 32'd0);

    // Stall: rr_ptr=1, fill slots 0 (tag 12) and 2 (tag 13)
    applyStimulus(3'b101, {4'd13, 4'd0, 4'd12}, {32'hCD13, 32'h0, 32'hCD12});
    tick();
    applyStimulus(3'b000, 12'h000, 96'h0);
    tick();
    checkCdb("stall.pre", 1'b1, 4'd13, 32'hCD13, 2'd2);
    rdy_in = 1'b0;
    #1;
    checkOutput("stall.ready", 32'(req_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkCdb($sformatf("stall.hold%0d", k), 1'b1, 4'd13, 32'hCD13, 2'd2);
      checkOutput($sformatf("stall.full%0d", k), 32'(dut.full), 32'b001);
    end
    rdy_in = 1'b1;
    tick();
    checkCdb("stall.resume", 1'b1, 4'd12, 32'hCD12, 2'd0);

    // Asynchronous reset mid-cycle
    #2;
    rst_in = 1'b0;
    #1;
    checkCdb("areset", 1'b0, 4'd0, 32'h0, 2'd0);
    checkOutput("areset.ready", 32'(req_ready), 32'h0);
    checkOutput("areset.full", 32'(dut.full), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
